// File: rtl/mux4_to_1_suite_pkg.sv
// Shared constants for the 4:1 mux suite: channel count, select width, select codes.
package mux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_A0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_A1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_A2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_A3 = 2'd3;

endpackage

// File: rtl/mux4_to_1_suite_if.sv
// Bus bundle for the mux suite: data/select in, per-model results and status out.
interface mux4_to_1_suite_if
  import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
);

    logic [NUM_CH*WIDTH-1:0] a;
    logic [SEL_W-1:0]        s;
    logic [WIDTH-1:0]        out_gate;
    logic [WIDTH-1:0]        out_dataflow;
    logic [WIDTH-1:0]        out_behavioral;
    logic [WIDTH-1:0]        out_structural;
    logic [WIDTH-1:0]        out_q;
    logic                    mismatch_q;
    logic                    err_sticky;

    modport master (
        output a, s,
        input  out_gate, out_dataflow, out_behavioral, out_structural,
        input  out_q, mismatch_q, err_sticky
    );

    modport slave (
        input  a, s,
        output out_gate, out_dataflow, out_behavioral, out_structural,
        output out_q, mismatch_q, err_sticky
    );

endinterface

// File: rtl/mux4_to_1_suite_mux2.sv
// 2:1 mux building block used by the structural model.
module mux2_to_1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux4_to_1_suite.sv
// Four equivalent 4:1 mux models computed side by side, with a registered
// result and a registered/sticky cross-model disagreement flag.
module mux4_to_1_suite
  import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input logic              clk,
    input logic              rst_n,
    mux4_to_1_suite_if.slave bus
);

    logic [WIDTH-1:0] a0, a1, a2, a3;
    logic [WIDTH-1:0] gate_y, flow_y, beh_y, struct_y;
    logic [WIDTH-1:0] lo_y, hi_y;
    logic             s0, s1, ns0, ns1;
    logic             any_diff;

    assign a0 = bus.a[0*WIDTH +: WIDTH];
    assign a1 = bus.a[1*WIDTH +: WIDTH];
    assign a2 = bus.a[2*WIDTH +: WIDTH];
    assign a3 = bus.a[3*WIDTH +: WIDTH];
    assign s0 = bus.s[0];
    assign s1 = bus.s[1];

    // Gate model: sum of products from primitives, one term set per data bit
    not g_ns0 (ns0, s0);
    not g_ns1 (ns1, s1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic t0, t1, t2, t3;
        and g_t0 (t0, ns1, ns0, a0[i]);
        and g_t1 (t1, ns1, s0,  a1[i]);
        and g_t2 (t2, s1,  ns0, a2[i]);
        and g_t3 (t3, s1,  s0,  a3[i]);
        or  g_or (gate_y[i], t0, t1, t2, t3);
    end

    assign flow_y = s1 ? (s0 ? a3 : a2) : (s0 ? a1 : a0);

    always_comb begin
        beh_y = '0;
        case (bus.s)
            SEL_A0:  beh_y = a0;
            SEL_A1:  beh_y = a1;
            SEL_A2:  beh_y = a2;
            SEL_A3:  beh_y = a3;
            default: beh_y = '0;
        endcase
    end

    mux2_to_1 #(.WIDTH(WIDTH)) u_lo  (.d0(a0),   .d1(a1),   .sel(s0), .y(lo_y));
    mux2_to_1 #(.WIDTH(WIDTH)) u_hi  (.d0(a2),   .d1(a3),   .sel(s0), .y(hi_y));
    mux2_to_1 #(.WIDTH(WIDTH)) u_out (.d0(lo_y), .d1(hi_y), .sel(s1), .y(struct_y));

    assign bus.out_gate       = gate_y;
    assign bus.out_dataflow   = flow_y;
    assign bus.out_behavioral = beh_y;
    assign bus.out_structural = struct_y;

    // Compare the bus-visible values so a disturbed output is seen by the checker
    assign any_diff = (bus.out_gate != bus.out_dataflow)
                    | (bus.out_gate != bus.out_behavioral)
                    | (bus.out_gate != bus.out_structural);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_q      <= '0;
            bus.mismatch_q <= 1'b0;
            bus.err_sticky <= 1'b0;
        end else begin
            bus.out_q      <= bus.out_behavioral;
            bus.mismatch_q <= any_diff;
            bus.err_sticky <= bus.err_sticky | bus.mismatch_q;
        end
    end

endmodule

// File: tb/tb_mux4_to_1_suite.sv
// Self-checking bench for mux4_to_1_suite against a shift-and-mask reference.
module tb_mux4_to_1_suite;

    localparam int unsigned WIDTH = 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux4_to_1_suite_if #(.WIDTH(WIDTH)) bus ();

    mux4_to_1_suite #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_mux(input logic [4*WIDTH-1:0] a, input logic [1:0] s);
        logic [4*WIDTH-1:0] sh;
        sh = a >> (int'(s) * WIDTH);
        return sh[WIDTH-1:0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.a = 4'b1111;
        bus.s = 2'b00;
        #1;
        checks++;
        if (bus.out_q !== 1'b0) begin errors++; $display("FAIL reset_out_q got %b want 0", bus.out_q); end
        checks++;
        if (bus.mismatch_q !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", bus.mismatch_q); end
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", bus.err_sticky); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_q !== 1'b1) begin errors++; $display("FAIL release_out_q got %b want 1", bus.out_q); end
    endtask

    task automatic check_comb(input string name, input logic [WIDTH-1:0] exp);
        logic [WIDTH-1:0] outs [4];
        outs[0] = bus.out_gate;
        outs[1] = bus.out_dataflow;
        outs[2] = bus.out_behavioral;
        outs[3] = bus.out_structural;
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (outs[m] !== exp) begin
                errors++;
                $display("FAIL %s model%0d s=%b a=%b got %b want %b", name, m, bus.s, bus.a, outs[m], exp);
            end
        end
    endtask

    task automatic test_select_walk();
        logic [1:0] st [9];
        logic [3:0] at [9];
        logic       et [9];
        st = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00};
        at = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b1010, 4'b0110, 4'b1111};
        et = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 9; k++) begin
            bus.s = st[k];
            bus.a = at[k];
            #1;
            check_comb(k < 5 ? "walk" : "ignore", et[k]);
            #1;
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        bus.s = 2'b11;
        bus.a = 4'b1000;
        @(posedge clk); #1;
        bus.s = 2'b00;
        bus.a = 4'b0000;
        checks++;
        if (bus.out_q !== 1'b1) begin errors++; $display("FAIL latency_first got %b want 1", bus.out_q); end
        @(posedge clk); #1;
        checks++;
        if (bus.out_q !== 1'b0) begin errors++; $display("FAIL latency_second got %b want 0", bus.out_q); end
    endtask

    task automatic test_sweep();
        for (int sv = 0; sv < 4; sv++) begin
            for (int av = 0; av < 16; av++) begin
                logic [WIDTH-1:0] exp;
                @(negedge clk);
                bus.s = 2'(sv);
                bus.a = 4'(av);
                exp = ref_mux(4'(av), 2'(sv));
                #1;
                check_comb("sweep", exp);
                @(posedge clk); #1;
                checks++;
                if (bus.out_q !== exp || bus.mismatch_q !== 1'b0 || bus.err_sticky !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_reg s=%0d a=%0d got q=%b mm=%b st=%b want q=%b mm=0 st=0",
                             sv, av, bus.out_q, bus.mismatch_q, bus.err_sticky, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] pending [$];
        for (int n = 0; n < 200; n++) begin
            logic [WIDTH-1:0] exp_q;
            @(negedge clk);
            bus.a = 4'($urandom);
            bus.s = 2'($urandom);
            #1;
            check_comb("random", ref_mux(bus.a, bus.s));
            pending.push_back(ref_mux(bus.a, bus.s));
            // change inputs mid-cycle sometimes; the captured value is the settled one
            if ($urandom_range(0, 3) == 0) begin
                bus.a = 4'($urandom);
                bus.s = 2'($urandom);
                #1;
                pending[pending.size()-1] = ref_mux(bus.a, bus.s);
            end
            @(posedge clk); #1;
            exp_q = pending.pop_front();
            checks++;
            if (bus.out_q !== exp_q) begin errors++; $display("FAIL random_q iter=%0d got %b want %b", n, bus.out_q, exp_q); end
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        bus.s = 2'b11;
        bus.a = 4'b1000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_q !== 1'b0) begin errors++; $display("FAIL midreset_async got %b want 0", bus.out_q); end
        @(posedge clk); #1;
        checks++;
        if (bus.out_q !== 1'b0) begin errors++; $display("FAIL midreset_hold got %b want 0", bus.out_q); end
        check_comb("midreset_comb", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_q !== 1'b1) begin errors++; $display("FAIL midreset_release got %b want 1", bus.out_q); end
    endtask

    task automatic test_fault();
        @(negedge clk);
        bus.s = 2'b00;
        bus.a = 4'b0001;
        force bus.out_structural = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.mismatch_q !== 1'b1) begin errors++; $display("FAIL fault_mismatch got %b want 1", bus.mismatch_q); end
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL fault_sticky_early got %b want 0", bus.err_sticky); end
        release bus.out_structural;
        @(posedge clk); #1;
        checks++;
        if (bus.err_sticky !== 1'b1 || bus.mismatch_q !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky_set got st=%b mm=%b want st=1 mm=0", bus.err_sticky, bus.mismatch_q);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.err_sticky !== 1'b1) begin errors++; $display("FAIL fault_sticky_hold got %b want 1", bus.err_sticky); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL fault_sticky_clear got %b want 0", bus.err_sticky); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_select_walk();
        test_latency();
        test_sweep();
        test_random();
        test_reset_midop();
        test_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
